nn_dense_layer: RTL and testbench
=================================

// Module: nn_dense_layer
// PURPOSE
//  Parametrised fully-connected layer for the classifier/decoder datapath.
//  Streams one input element per accepted beat and multiplies it by N_OUT weights in parallel.
//  Accumulates N_IN beats, then adds a per-output bias, saturates and optionally applies ReLU.
//  Replaces fixed-length, single-neuron, counter-timed MACs with a start/valid/done handshake.
// PARAMETERS
//  DATA_W  16  signed fixed-point width of x, w, bias, y
//  FRAC_W  8   fractional bits of x, w, bias, y (Q(DATA_W-FRAC_W).FRAC_W)
//  N_IN    9   beats (input elements) per dot product, >=1
//  N_OUT   2   output neurons (parallel MAC lanes), >=1
//  ACC_W   40  accumulator width, >= 2*DATA_W + clog2(N_IN)
// PORTS
//  clk      in   1             clock, rising edge
//  rst      in   1             reset, asynchronous, active-low
//  clr      in   1             synchronous abort: go IDLE, clear accumulators
//  start    in   1             begin new dot product (sampled only in IDLE)
//  relu_en  in   1             apply ReLU to outputs (latched at start)
//  bias     in   N_OUT*DATA_W  per-lane bias, lane j at [j*DATA_W +: DATA_W] (latched at start)
//  in_valid in   1             beat valid
//  in_ready out  1             block accepts beat (high only in ACCUM)
//  in_x     in   DATA_W        input element, shared by all lanes
//  in_w     in   N_OUT*DATA_W  weights for this beat, lane j at [j*DATA_W +: DATA_W]
//  busy     out  1             operation in progress (ACCUM or FINAL)
//  out_valid out 1             one-cycle pulse: out_y updated
//  out_y    out  N_OUT*DATA_W  registered results, held until next out_valid
// BEHAVIOUR
//  Reset (rst=0): state IDLE; accumulators, beat counter, out_y, out_valid,
//   busy, in_ready, and latched bias/relu all 0.
//  FSM IDLE -> ACCUM on start; ACCUM -> FINAL on accept of beat N_IN-1;
//   FINAL -> IDLE unconditionally after 1 cycle.
//  start in ACCUM/FINAL ignored. in_valid outside ACCUM ignored (no accept).
//  Entry to ACCUM clears all accumulators and the counter.
//  Beat accept = in_valid & in_ready. Per lane: acc_j += sext(x*w_j), full 2*DATA_W product.
//  Gaps in in_valid stall; the result is independent of gap pattern.
//  FINAL, per lane:
//   s = (acc_j >>> FRAC_W) + sext(bias_j), arithmetic shift = floor.
//   Saturate s to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//   If relu_en and the value is negative, output 0.
//   Register the result into out_y and pulse out_valid.
//  Latency: out_valid is high in the 2nd cycle after the edge that accepts the last beat.
//   Exactly 1 cycle; busy already 0 in that cycle.
//  Back-to-back: start in the out_valid cycle begins the next op; in_ready is high on the next cycle.
//  clr: highest priority after rst, any state -> IDLE.
//   Accumulators and counter cleared; out_y keeps its old value; no out_valid.
//  clr and start in the same cycle: clr wins; start is dropped.
//  Counter wraps to 0 at FINAL; it never exceeds N_IN-1.
// STRUCTURE
//  Package nn_pkg:
//   DATA_W/FRAC_W defaults, state enum {IDLE,ACCUM,FINAL}.
//   Function sat_to_data(signed wide) -> DATA_W.
//  Sub-module nn_mac_lane (one per output via generate):
//   acc register, clear/accumulate enables, FINAL shift/bias/sat/ReLU.
//  Top holds the FSM, beat counter, bias/relu latches and the out_valid pulse.
// TESTING (N_IN=3, N_OUT=2, DATA_W=16, FRAC_W=8; 1.0=256)
//  1 x=[256,512,-256], w0=[256,256,256], w1=[-256,0,0], bias=[128,0], relu=0
//    -> y0=640, y1=-256; out_valid 1 cycle, 2 cycles after last beat.
//  2 Same as 1 with relu=1 -> y0=640, y1=0.
//  3 x=w0=32767 all beats, w1=-32768 -> y0=32767 (sat high), y1=-32768 (sat low).
//  4 Test 1 with in_valid gaps of 0..4 cycles -> identical y.
//    in_ready=0 in IDLE/FINAL; extra beats are not accepted.
//  5 start pulsed mid-ACCUM -> ignored, result unchanged.
//    start in the out_valid cycle -> second op correct, no accumulator carry-over.
//  6 rst=0 after beat 2 -> all outputs 0 immediately; the next op gives test 1 values.
//    clr after beat 1 -> IDLE, no out_valid, out_y unchanged.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and helpers for the dense-layer datapath.
// Fixed-point defaults, FSM state encoding and saturation.
package nn_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 8;
  localparam int DEF_ACC_W  = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2
  } state_t;

  // Clamp v to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_to_data(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/nn_mac_lane.sv
// One output neuron: accumulator plus bias, saturation and ReLU
// applied combinationally to the final sum.
module nn_mac_lane
  import nn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_acc_en,
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_w,
  input  logic [DATA_W-1:0] i_bias,
  input  logic              i_relu,
  output logic [DATA_W-1:0] o_y
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = ACC_W + 1;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_shift;
  logic signed [SW-1:0]    w_sum;
  logic signed [63:0]      w_sat;
  logic [DATA_W-1:0]       w_y;
  logic                    w_unused;

  assign w_prod     = $signed(i_x) * $signed(i_w);
  assign w_prod_ext = ACC_W'(w_prod);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_acc_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  // Arithmetic shift drops fraction bits of the product (floor).
  assign w_shift = r_acc >>> FRAC_W;
  assign w_sum   = SW'(w_shift) + SW'($signed(i_bias));
  assign w_sat   = sat_to_data(64'(w_sum), DATA_W);
  assign w_y     = w_sat[DATA_W-1:0];
  assign w_unused = ^w_sat[63:DATA_W];

  always_comb begin
    o_y = w_y;
    if (i_relu && w_y[DATA_W-1]) begin
      o_y = '0;
    end
  end

endmodule

// File: rtl/nn_dense_layer.sv
// Fully-connected layer: streams N_IN beats into N_OUT parallel MACs
// and emits biased, saturated, optionally rectified results.
module nn_dense_layer
  import nn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int N_IN   = 9,
  parameter int N_OUT  = 2,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    start,
  input  logic                    relu_en,
  input  logic [N_OUT*DATA_W-1:0] bias,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_x,
  input  logic [N_OUT*DATA_W-1:0] in_w,
  output logic                    busy,
  output logic                    out_valid,
  output logic [N_OUT*DATA_W-1:0] out_y
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [N_OUT*DATA_W-1:0] r_bias;
  logic                    r_relu;
  logic                    r_in_ready;
  logic                    r_busy;
  logic                    r_out_valid;
  logic [N_OUT*DATA_W-1:0] r_out_y;

  logic                    w_accept;
  logic                    w_acc_clr;
  logic [N_OUT*DATA_W-1:0] w_y;

  assign w_accept  = in_valid & r_in_ready;
  assign w_acc_clr = clr | ((r_state == IDLE) & start);

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bias      <= '0;
      r_relu      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
    end else if (clr) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= ACCUM;
            r_cnt      <= '0;
            r_bias     <= bias;
            r_relu     <= relu_en;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            if (r_cnt == LAST) begin
              r_state    <= FINAL;
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        FINAL: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b1;
          r_out_y     <= w_y;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    nn_mac_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_acc_clr),
      .i_acc_en (w_accept),
      .i_x      (in_x),
      .i_w      (in_w[j*DATA_W +: DATA_W]),
      .i_bias   (r_bias[j*DATA_W +: DATA_W]),
      .i_relu   (r_relu),
      .o_y      (w_y[j*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_nn_dense_layer.sv
// Directed bench for nn_dense_layer with a result scoreboard.
// Expected outputs come from a bench-side integer model.
module tb_nn_dense_layer;

  localparam int DW   = 16;
  localparam int NIN  = 3;
  localparam int NOUT = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            clr = 1'b0;
  logic            start = 1'b0;
  logic            relu_en = 1'b0;
  logic [NOUT*DW-1:0] bias = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_x = '0;
  logic [NOUT*DW-1:0] in_w = '0;
  logic            busy;
  logic            out_valid;
  logic [NOUT*DW-1:0] out_y;

  nn_dense_layer #(
    .DATA_W (DW),
    .FRAC_W (8),
    .N_IN   (NIN),
    .N_OUT  (NOUT),
    .ACC_W  (40)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .start     (start),
    .relu_en   (relu_en),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .busy      (busy),
    .out_valid (out_valid),
    .out_y     (out_y)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] sbq[$];

  int gx[3];
  int gw0[3];
  int gw1[3];
  int gb0;
  int gb1;
  bit grelu;
  logic [31:0] saved_y;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input int ws[3], input int b);
    longint acc;
    longint s;
    acc = 0;
    for (int i = 0; i < 3; i++) acc += longint'(gx[i]) * longint'(ws[i]);
    s = (acc >>> 8) + longint'(b);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (grelu && s < 0) s = 0;
    return 16'(s);
  endfunction

  always @(negedge clk) begin
    if (rst && out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        chk("out_y", out_y, sbq.pop_front());
        chk("busy_at_valid", {31'b0, busy}, 32'd0);
      end
    end
  end

  task automatic start_op();
    start   = 1'b1;
    relu_en = grelu;
    bias    = {16'(gb1), 16'(gb0)};
    @(posedge clk); #1;
    start   = 1'b0;
    relu_en = 1'b0;
    bias    = '0;
    chk("ready_after_start", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic beats(input int first, input int last,
                       input bit gaps, input bit poke);
    for (int i = first; i <= last; i++) begin
      int k;
      int g;
      g = gaps ? 2 * i : 0;
      repeat (g) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_x     = 16'(gx[i]);
      in_w     = {16'(gw1[i]), 16'(gw0[i])};
      if (poke && i == 1) start = 1'b1;
      k = 0;
      while (!in_ready && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
      if (k >= 20) chk("beat_timeout", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      start    = 1'b0;
      in_x     = '0;
      in_w     = '0;
    end
  endtask

  task automatic expect_cur();
    sbq.push_back({model(gw1, gb1), model(gw0, gb0)});
  endtask

  task automatic finish(input bit chain);
    @(negedge clk);
    chk("final_busy", {31'b0, busy}, 32'd1);
    chk("final_ready", {31'b0, in_ready}, 32'd0);
    chk("final_no_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("valid_latency", {31'b0, out_valid}, 32'd1);
    if (chain) begin
      start_op();
    end else begin
      @(posedge clk); #1;
    end
    chk("valid_pulse_len", {31'b0, out_valid}, 32'd0);
  endtask

  task automatic set_t1();
    gx  = '{256, 512, -256};
    gw0 = '{256, 256, 256};
    gw1 = '{-256, 0, 0};
    gb0 = 128;
    gb1 = 0;
    grelu = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_y", out_y, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    set_t1();
    start_op();
    beats(0, 2, 1'b0, 1'b0);
    expect_cur();
    finish(1'b0);
    chk("t1_y", out_y, {16'hFF00, 16'd640});

    grelu = 1'b1;
    start_op();
    beats(0, 2, 1'b0, 1'b0);
    expect_cur();
    finish(1'b0);
    chk("t2_y", out_y, {16'h0000, 16'd640});

    gx  = '{32767, 32767, 32767};
    gw0 = '{32767, 32767, 32767};
    gw1 = '{-32768, -32768, -32768};
    gb0 = 0;
    gb1 = 0;
    grelu = 1'b0;
    start_op();
    beats(0, 2, 1'b0, 1'b0);
    expect_cur();
    finish(1'b0);
    chk("t3_sat", out_y, {16'h8000, 16'h7FFF});

    set_t1();
    start_op();
    beats(0, 2, 1'b1, 1'b0);
    expect_cur();
    finish(1'b0);
    chk("t4_gap_y", out_y, {16'hFF00, 16'd640});

    in_valid = 1'b1;
    in_x = 16'd1000;
    in_w = {16'd1000, 16'd1000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_y_held", out_y, {16'hFF00, 16'd640});

    start_op();
    beats(0, 2, 1'b0, 1'b1);
    expect_cur();
    grelu = 1'b1;
    gb0 = -1000;
    finish(1'b1);
    beats(0, 2, 1'b0, 1'b0);
    expect_cur();
    finish(1'b0);
    chk("t5_chain_y", out_y, {16'h0000, 16'h0000});

    set_t1();
    start_op();
    beats(0, 1, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_y", out_y, 32'd0);
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    start_op();
    beats(0, 2, 1'b0, 1'b0);
    expect_cur();
    finish(1'b0);
    chk("t6_after_rst", out_y, {16'hFF00, 16'd640});

    saved_y = out_y;
    gb0 = 5;
    start_op();
    beats(0, 0, 1'b0, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_busy", {31'b0, busy}, 32'd0);
    chk("clr_ready", {31'b0, in_ready}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("clr_y_held", out_y, saved_y);

    clr = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    start = 1'b0;
    chk("clr_start_busy", {31'b0, busy}, 32'd0);
    chk("clr_start_ready", {31'b0, in_ready}, 32'd0);

    set_t1();
    start_op();
    beats(0, 2, 1'b0, 1'b0);
    expect_cur();
    finish(1'b0);
    chk("post_clr_y", out_y, {16'hFF00, 16'd640});

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
